// File: rtl/spectrum_ram_pkg.sv
// rtl/spectrum_ram_pkg.sv - shared types, sizes and bank-address helper for spectrum_ram_ctrl
package spectrum_ram_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_t;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int MAX_ADDR_WIDTH = 16;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;
    localparam int DROP_CNT_WIDTH = 16;

    // Places the bank select just above an aw-bit bin index; callers cast to aw+1 bits.
    function automatic logic [MAX_ADDR_WIDTH:0] bank_addr(
        input logic                      bank,
        input logic [MAX_ADDR_WIDTH-1:0] idx,
        input int unsigned               aw
    );
        logic [MAX_ADDR_WIDTH:0] sel;
        sel = {{MAX_ADDR_WIDTH{1'b0}}, bank} << aw;
        return sel | {1'b0, idx};
    endfunction

endpackage

// File: rtl/spectrum_wr_seq.sv
// rtl/spectrum_wr_seq.sv - fill/full sequencer: frame write counter, bank select, vsync-aligned swap
// Optional SPECTRUM_RAM_DROP_EN: never backpressure, discard frames arriving while full.
module spectrum_wr_seq
    import spectrum_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic                  vsync_pulse,
    output logic                  s_ready,
    output logic                  beat_wr,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_cnt,
    output logic                  frame_swapped
`ifdef SPECTRUM_RAM_DROP_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    wr_state_t             state, state_nxt;
    logic                  wr_bank_nxt;
    logic [ADDR_WIDTH-1:0] wr_cnt_nxt;
    logic                  frame_end;

`ifdef SPECTRUM_RAM_DROP_EN
    logic                      dropping, dropping_nxt;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_nxt;
`endif

    assign frame_end = s_last || (wr_cnt == LAST_IDX);

    always_comb begin
        state_nxt     = state;
        wr_bank_nxt   = wr_bank;
        wr_cnt_nxt    = wr_cnt;
        frame_swapped = 1'b0;
        beat_wr       = 1'b0;
`ifdef SPECTRUM_RAM_DROP_EN
        dropping_nxt  = dropping;
        drop_cnt_nxt  = drop_cnt;
        s_ready       = !rst;
`else
        s_ready       = !rst && (state == FILL);
`endif

        if (s_valid && s_ready) begin
`ifdef SPECTRUM_RAM_DROP_EN
            // A frame that started while full is discarded to its end, even across a swap.
            if (state == FULL || dropping) begin
                wr_cnt_nxt   = frame_end ? '0 : wr_cnt + 1'b1;
                dropping_nxt = !frame_end;
                if (frame_end && drop_cnt != '1) begin
                    drop_cnt_nxt = drop_cnt + 1'b1;
                end
            end else
`endif
            begin
                beat_wr = 1'b1;
                if (frame_end) begin
                    wr_cnt_nxt = '0;
                    state_nxt  = FULL;
                end else begin
                    wr_cnt_nxt = wr_cnt + 1'b1;
                end
            end
        end

        if (!rst && state == FULL && vsync_pulse) begin
            wr_bank_nxt   = ~wr_bank;
            frame_swapped = 1'b1;
            state_nxt     = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
`ifdef SPECTRUM_RAM_DROP_EN
            dropping <= 1'b0;
            drop_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            wr_bank  <= wr_bank_nxt;
            wr_cnt   <= wr_cnt_nxt;
`ifdef SPECTRUM_RAM_DROP_EN
            dropping <= dropping_nxt;
            drop_cnt <= drop_cnt_nxt;
`endif
        end
    end

endmodule

// File: rtl/spectrum_ram_ctrl.sv
// rtl/spectrum_ram_ctrl.sv - double-buffered spectrum RAM controller with tear-free swap and 1-cycle reads
// Optional SPECTRUM_RAM_DROP_EN adds drop-instead-of-stall mode and the drop_cnt port.
module spectrum_ram_ctrl
    import spectrum_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  vsync_pulse,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH:0]   ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_web,
    output logic [ADDR_WIDTH:0]   ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic                  frame_swapped
`ifdef SPECTRUM_RAM_DROP_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

    logic                  beat_wr;
    logic                  wr_bank;
    logic [ADDR_WIDTH-1:0] wr_cnt;

    spectrum_wr_seq #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_wr_seq (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .vsync_pulse  (vsync_pulse),
        .s_ready      (s_ready),
        .beat_wr      (beat_wr),
        .wr_bank      (wr_bank),
        .wr_cnt       (wr_cnt),
        .frame_swapped(frame_swapped)
`ifdef SPECTRUM_RAM_DROP_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    // Write port is idle-zero so the RAM sees clean inputs outside beats and in reset.
    assign ram_wea   = beat_wr;
    assign ram_addra = beat_wr
        ? (ADDR_WIDTH+1)'(bank_addr(wr_bank, MAX_ADDR_WIDTH'(wr_cnt), ADDR_WIDTH))
        : '0;
    assign ram_dina  = beat_wr ? s_data : '0;

    // Display always reads the bank opposite the writer, so ports never collide.
    assign ram_web   = rd_en;
    assign ram_addrb = (ADDR_WIDTH+1)'(bank_addr(~wr_bank, MAX_ADDR_WIDTH'(rd_addr), ADDR_WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? ram_doutb : '0;
        end
    end

endmodule
